// File: rtl/matrix_mover.sv
// Sequential transfer engine: loads eight 32-bit memory words into a 256-bit
// matrix register, or stores a captured 256-bit matrix back as eight words.
module matrix_mover #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              dir_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [255:0]      matrix_in_i,
    output logic [255:0]      matrix_out_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i,
    input  logic              mem_ack_i
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [2:0]          row_q, row_d;
    logic                dir_q, dir_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [255:0]        shadow_q, shadow_d;
    logic [255:0]        matrix_out_q, matrix_out_d;

    logic                last_row;
    logic                xfer;
    logic [7:0]          row_lsb;

    assign last_row = (row_q == 3'd7);
    assign xfer     = (state_q == S_REQ) && mem_ack_i;
    assign row_lsb  = {row_q, 5'b0};

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start_i) state_d = S_REQ;
            S_REQ:   if (mem_ack_i && last_row) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o      = 1'b0;
        done_o      = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        unique case (state_q)
            S_REQ: begin
                busy_o      = 1'b1;
                mem_req_o   = 1'b1;
                mem_we_o    = dir_q;
                mem_addr_o  = base_q + ADDR_W'(row_q);
                mem_wdata_o = dir_q ? shadow_q[row_lsb +: 32] : 32'd0;
            end
            S_DONE: begin
                busy_o = 1'b1;
                done_o = 1'b1;
            end
            default: ;
        endcase
    end

    // Loads assemble in the shadow; matrix_out only takes the finished matrix.
    always_comb begin
        row_d        = row_q;
        dir_d        = dir_q;
        base_d       = base_q;
        shadow_d     = shadow_q;
        matrix_out_d = matrix_out_q;
        if (state_q == S_IDLE && start_i) begin
            dir_d  = dir_i;
            base_d = base_addr_i;
            row_d  = '0;
            if (dir_i) shadow_d = matrix_in_i;
        end
        if (xfer) begin
            if (!dir_q) shadow_d[row_lsb +: 32] = mem_rdata_i;
            if (last_row) begin
                if (!dir_q) matrix_out_d = shadow_d;
            end else begin
                row_d = row_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q        <= '0;
            matrix_out_q <= '0;
        end else begin
            row_q        <= row_d;
            matrix_out_q <= matrix_out_d;
        end
    end

    // NOTE: command registers carry no reset; every start reloads them before use.
    always_ff @(posedge clk) begin
        dir_q    <= dir_d;
        base_q   <= base_d;
        shadow_q <= shadow_d;
    end

    assign matrix_out_o = matrix_out_q;

endmodule

// File: doc/matrix_mover.md
# matrix_mover

Sequential transfer engine between the 32-bit data memory and the 256-bit matrix operand/result datapath of the matrix processor. Load operation: reads eight consecutive memory words and assembles them into one 8x8 matrix of 4-bit elements for the ALU operand registers. Store operation: does the reverse and writes an ALU result matrix back as eight words. It is the memory-side counterpart of the matrix ALU: it produces matrix operands and consumes matrix results.

## Interface

- ADDR_W, 8, memory word-address width
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  command strobe, sampled only in IDLE
- dir  input  1  0 = load (memory to matrix_out), 1 = store (matrix_in to memory); sampled with start
- base_addr  input  ADDR_W  word address of row 0; sampled with start
- matrix_in  input  256  store source; sampled with start
- matrix_out  output  256  last fully loaded matrix
- busy  output  1  high from the cycle after an accepted start through the done cycle
- done  output  1  one-cycle pulse when a command completes
- mem_req  output  1  memory request valid
- mem_we  output  1  1 = write, 0 = read; valid with mem_req
- mem_addr  output  ADDR_W  word address; valid with mem_req
- mem_wdata  output  32  write data; valid with mem_req and mem_we
- mem_rdata  input  32  read data; valid in the mem_ack cycle of a read
- mem_ack  input  1  memory completes the current request this cycle

## Operation

- Matrix layout: row r occupies bits [r*32 +: 32]. Element (r,c) is the nibble at bit r*32+28-c*4, so column 0 is the row's MSB nibble. Row r maps to memory word base_addr+r.
- Address arithmetic is modulo 2^ADDR_W. Base 0xFE covers addresses 0xFE, 0xFF, 0x00 … 0x05.
- State machine:
  - IDLE: start=1 captures dir, base_addr and matrix_in (store only) into a shadow register, clears the row counter to 0, and moves to REQ.
  - REQ: drives mem_req=1, mem_we=dir, mem_addr=base+row and mem_wdata=shadow[row*32 +: 32]. On mem_ack:
    - Load: mem_rdata is written into shadow row `row`.
    - If row=7, go to DONE.
    - Otherwise increment row and stay in REQ.
  - DONE: done=1 for one cycle. For a load, matrix_out is assigned the full shadow register in the same edge that enters DONE. Next state is IDLE.
- matrix_out never shows a partially loaded matrix. A store never changes matrix_out.
- start while busy is ignored; no queueing. start in the DONE cycle is also ignored.
- Changes on matrix_in, dir or base_addr after start is accepted have no effect on the command in flight.
- mem_ack while mem_req=0 is ignored.

## Timing

- Reset values: matrix_out=0, busy=0, done=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0. Row counter=0, state=IDLE.
- Reset mid-command aborts it:
  - next cycle is IDLE with mem_req=0;
  - a partially assembled load is discarded and matrix_out returns to 0;
  - no done pulse is issued.
- Request handshake:
  - mem_addr, mem_we and mem_wdata stay stable while mem_req=1 and mem_ack=0.
  - A transfer completes in the cycle where mem_req and mem_ack are both high.
  - Back-to-back transfers: mem_req stays high and the address advances on the edge after the ack.
- Zero-wait memory (ack every cycle), start in cycle 0:
  - rows 0–7 on cycles 1–8;
  - done and the updated matrix_out in cycle 9;
  - next start accepted in cycle 10.
- With W total wait cycles, done occurs at cycle 9+W.
- busy is high in REQ and DONE, and low in IDLE.
- mem_req drops to 0 in the DONE cycle.

## Test plan

- Zero-wait load: base=0x10, memory words 0x10+r = 0x01234567+r. Required:
  - done pulses in cycle 9;
  - matrix_out[31:0]=0x01234567 and matrix_out[255:224]=0x0123456E;
  - matrix_out stays 0 through cycle 8.
- Store with wait states: matrix_in has row r = {8{r[3:0]}}, base=0x40, one wait cycle per request. Required:
  - eight writes, to 0x40..0x47, with data 0x00000000..0x77777777;
  - mem_addr/mem_wdata held during each wait;
  - done in cycle 17.
- Address wrap: load with base=0xFE. Required: addresses 0xFE, 0xFF, 0x00..0x05; row 2 comes from address 0x00.
- Busy interlock: start re-asserted with dir=1 in cycles 3 and 9 of a load, and matrix_in changed in cycle 2 of a store. Required:
  - both extra starts ignored (no second command);
  - the store writes the originally captured data.
- Reset mid-load: load, assert rst in cycle 5 after matrix_out holds a prior value. Required:
  - next cycle mem_req=0, busy=0, matrix_out=0;
  - no done pulse;
  - a fresh load then completes normally.
